// File: rtl/postadder_normalizer.sv
// Post-adder normalizer: resolves a redundant limb vector with signed per-limb carries
// into one signed integer, then reduces it into [0, Mod) by repeated +/- Mod.
package postadder_pkg;
  localparam int LW = 64;
  localparam int ADD_DIV = 4;
  localparam int FP_W = ADD_DIV * LW;

  typedef logic [LW-1:0]   fp_div4_t;
  typedef logic [FP_W-1:0] uint_fp_t;

  typedef struct packed {
    fp_div4_t   val;
    logic [7:0] carry;
  } limb_t;

  typedef limb_t [ADD_DIV-1:0] redundant_poly_L3;

  // BN254 base-field modulus (PARAMS_BN254_d0)
  localparam uint_fp_t PARAMS_BN254_D0_MOD =
    256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
endpackage

module postadder_normalizer
  import postadder_pkg::*;
#(
  parameter int MAX_REDUCE = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  redundant_poly_L3 in,
  output logic             out_valid,
  input  logic             out_ready,
  output uint_fp_t         dout,
  output logic             err
);

  localparam int TOP_W = 9;
  localparam int ACC_W = FP_W + TOP_W;
  localparam int KW    = $clog2(ADD_DIV);
  localparam int NW    = $clog2(MAX_REDUCE + 2);
  localparam int CW    = 10;

  localparam logic signed [ACC_W-1:0] MOD_EXT = {{TOP_W{1'b0}}, PARAMS_BN254_D0_MOD};

  typedef enum logic [1:0] {IDLE, RESOLVE, REDUCE, DONE} state_t;

  state_t                  state_reg;
  redundant_poly_L3        in_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic [KW-1:0]           k_reg;
  logic signed [CW-1:0]    c_reg;
  logic [NW-1:0]           n_reg;
  uint_fp_t                dout_reg;
  logic                    err_reg;

  logic [7:0]              carry_prev;
  logic [7:0]              carry_top;
  logic signed [LW+CW-1:0] s;
  logic signed [CW-1:0]    c_next;
  logic signed [CW-1:0]    top_sum;
  logic                    acc_neg;
  logic                    acc_ge;

  // Carry of limb k-1 lands at weight 2^(k*LW), i.e. it joins limb k's sum.
  always_comb begin
    carry_prev = (k_reg == '0) ? 8'h00 : in_reg[k_reg - KW'(1)].carry;
    carry_top  = in_reg[ADD_DIV-1].carry;
    s = $signed({{CW{1'b0}}, in_reg[k_reg].val})
      + $signed({{LW{c_reg[CW-1]}}, c_reg})
      + $signed({{(LW+CW-8){carry_prev[7]}}, carry_prev});
    c_next  = s[LW+CW-1:LW];
    top_sum = c_next + $signed({{(CW-8){carry_top[7]}}, carry_top});
    acc_neg = acc_reg[ACC_W-1];
    acc_ge  = !acc_neg && (acc_reg >= MOD_EXT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      in_reg    <= '0;
      acc_reg   <= '0;
      k_reg     <= '0;
      c_reg     <= '0;
      n_reg     <= '0;
      dout_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            in_reg    <= in;
            k_reg     <= '0;
            c_reg     <= '0;
            state_reg <= RESOLVE;
          end
        end
        RESOLVE: begin
          for (int i = 0; i < ADD_DIV; i++) begin
            if (k_reg == KW'(i)) acc_reg[i*LW +: LW] <= s[LW-1:0];
          end
          c_reg <= c_next;
          k_reg <= k_reg + KW'(1);
          if (k_reg == KW'(ADD_DIV - 1)) begin
            acc_reg[ACC_W-1 -: TOP_W] <= top_sum[TOP_W-1:0];
            n_reg     <= '0;
            state_reg <= REDUCE;
          end
        end
        REDUCE: begin
          if (acc_neg || acc_ge) begin
            // Budget exhausted: emit the partially reduced value with err set.
            if (n_reg == NW'(MAX_REDUCE)) begin
              err_reg   <= 1'b1;
              dout_reg  <= acc_reg[FP_W-1:0];
              state_reg <= DONE;
            end else begin
              acc_reg <= acc_neg ? (acc_reg + MOD_EXT) : (acc_reg - MOD_EXT);
              n_reg   <= n_reg + NW'(1);
            end
          end else begin
            err_reg   <= 1'b0;
            dout_reg  <= acc_reg[FP_W-1:0];
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE) && rstn;
  assign out_valid = (state_reg == DONE);
  assign dout      = dout_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_postadder_normalizer.sv
// Directed-vector bench for postadder_normalizer: table of encoded inputs with
// hand-derived results and latencies, plus back-pressure, in_valid-noise and reset sequences.
module tb_postadder_normalizer;
  import postadder_pkg::*;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  redundant_poly_L3 in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  uint_fp_t         dout;
  logic             err;

  int nvec = 0;
  int nmis = 0;

  postadder_normalizer #(.MAX_REDUCE(8)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    redundant_poly_L3 poly;
    uint_fp_t         dout;
    logic             err;
    int               lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [263:0] act, input logic [263:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic redundant_poly_L3 from_u(input logic [263:0] v);
    redundant_poly_L3 p;
    p = '0;
    for (int i = 0; i < ADD_DIV; i++) p[i].val = v[i*LW +: LW];
    p[ADD_DIV-1].carry = v[263:256];
    return p;
  endfunction

  // One transaction: accept, measure latency, optional back-pressure, out handshake.
  task automatic run(input redundant_poly_L3 p, input int hold, input bit pulse,
                     output uint_fp_t d, output logic e, output int lat);
    logic unstable;
    @(negedge clk);
    if (hold > 0) out_ready = 1'b0;
    chk("accept_ready", 264'(in_ready), 264'(1));
    in_data  = p;
    in_valid = 1'b1;
    @(posedge clk); #1;
    if (pulse) begin
      in_data = from_u(264'd99);
      repeat (2) @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    lat = pulse ? 2 : 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      nvec++; nmis++;
      $display("FAIL timeout: out_valid never rose, got 0 expected 1");
    end
    d = dout;
    e = err;
    if (hold > 0) begin
      unstable = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || dout !== d || err !== e || in_ready !== 1'b0) unstable = 1'b1;
      end
      chk("hold_stable", 264'(unstable), 264'(0));
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("post_hs_in_ready", 264'(in_ready), 264'(1));
    chk("post_hs_out_valid", 264'(out_valid), 264'(0));
  endtask

  initial begin
    logic [263:0] big_mod;
    logic [263:0] tmp;
    uint_fp_t     exp_d;
    uint_fp_t     d;
    logic         e;
    int           lat;
    int           extra;

    big_mod = 264'(PARAMS_BN254_D0_MOD);

    vecs[0].poly = '0;
    vecs[0].dout = '0;  vecs[0].err = 1'b0; vecs[0].lat = ADD_DIV + 1;

    vecs[1].poly = from_u(big_mod - 264'd1);
    vecs[1].dout = PARAMS_BN254_D0_MOD - 256'd1; vecs[1].err = 1'b0; vecs[1].lat = ADD_DIV + 1;

    vecs[2].poly = from_u(big_mod - 264'd1);
    vecs[2].poly[0].carry = 8'h01;
    exp_d = '0; exp_d[63:0] = '1;
    vecs[2].dout = exp_d; vecs[2].err = 1'b0; vecs[2].lat = ADD_DIV + 2;

    // 3*Mod+7 with +2^64 moved into carry0 and -2^128 into carry1
    vecs[3].poly = from_u(big_mod * 264'd3 + 264'd7);
    vecs[3].poly[0].carry = 8'h01;
    vecs[3].poly[1].val   = vecs[3].poly[1].val - 64'd1;
    vecs[3].poly[1].carry = 8'hFF;
    vecs[3].poly[2].val   = vecs[3].poly[2].val + 64'd1;
    vecs[3].dout = 256'd7; vecs[3].err = 1'b0; vecs[3].lat = ADD_DIV + 4;

    vecs[4].poly = '0;
    vecs[4].poly[0].carry = 8'hFF;
    exp_d = '0; exp_d[64] = 1'b1;
    vecs[4].dout = PARAMS_BN254_D0_MOD - exp_d; vecs[4].err = 1'b0; vecs[4].lat = ADD_DIV + 2;

    vecs[5].poly = from_u(big_mod * 264'd20);
    tmp = big_mod * 264'd12;
    vecs[5].dout = tmp[255:0]; vecs[5].err = 1'b1; vecs[5].lat = ADD_DIV + 9;

    vecs[6].poly = from_u(264'd5);
    vecs[6].dout = 256'd5; vecs[6].err = 1'b0; vecs[6].lat = ADD_DIV + 1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 264'(out_valid), 264'(0));
    chk("rst_in_ready", 264'(in_ready), 264'(0));
    chk("rst_dout", 264'(dout), 264'(0));
    chk("rst_err", 264'(err), 264'(0));
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run(vecs[i].poly, 0, 1'b0, d, e, lat);
      $display("vec %0d: dout=%h err=%0d lat=%0d", i, d, e, lat);
      chk($sformatf("vec%0d_dout", i), 264'(d), 264'(vecs[i].dout));
      chk($sformatf("vec%0d_err", i), 264'(e), 264'(vecs[i].err));
      chk($sformatf("vec%0d_lat", i), 264'(lat), 264'(vecs[i].lat));
    end

    // Back-pressure: consumer stalls 5 cycles in DONE
    run(vecs[3].poly, 5, 1'b0, d, e, lat);
    $display("hold: dout=%h err=%0d lat=%0d", d, e, lat);
    chk("hold_dout", 264'(d), 264'(256'd7));
    chk("hold_lat", 264'(lat), 264'(ADD_DIV + 4));

    // in_valid kept high during RESOLVE must not start a second transaction
    run(from_u(264'd5), 0, 1'b1, d, e, lat);
    $display("pulse: dout=%h err=%0d lat=%0d", d, e, lat);
    chk("pulse_dout", 264'(d), 264'(256'd5));
    chk("pulse_lat", 264'(lat), 264'(ADD_DIV + 1));
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    chk("pulse_no_second", 264'(extra), 264'(0));

    // Asynchronous reset in the middle of REDUCE
    @(negedge clk);
    in_data  = vecs[5].poly;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (ADD_DIV + 3) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    $display("reset mid-REDUCE: out_valid=%0d dout=%h", out_valid, dout);
    chk("arst_out_valid", 264'(out_valid), 264'(0));
    chk("arst_dout", 264'(dout), 264'(0));
    chk("arst_in_ready", 264'(in_ready), 264'(0));
    @(negedge clk);
    rstn = 1'b1;
    run(from_u(264'd42), 0, 1'b0, d, e, lat);
    $display("after reset: dout=%h err=%0d lat=%0d", d, e, lat);
    chk("post_rst_dout", 264'(d), 264'(256'd42));
    chk("post_rst_err", 264'(e), 264'(0));
    chk("post_rst_lat", 264'(lat), 264'(ADD_DIV + 1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
